// File: rtl/test_mem_pkg.sv
// Shared defaults and the fixed instruction ROM image for test_mem.
package test_mem_pkg;

  localparam int unsigned ROM_DATA_W = 16;
  localparam int unsigned ROM_ADDR_W = 5;

  // Unlisted addresses read as zero.
  function automatic logic [ROM_DATA_W-1:0] rom_word(input logic [ROM_ADDR_W-1:0] a);
    logic [ROM_DATA_W-1:0] w;
    case (a)
      5'd0:    w = 16'h2000;
      5'd1:    w = 16'h0005;
      5'd2:    w = 16'h2200;
      5'd3:    w = 16'h0003;
      5'd4:    w = 16'h4200;
      5'd5:    w = 16'h6200;
      5'd6:    w = 16'h0080;
      5'd7:    w = 16'h0000;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/test_mem_addr_ctr.sv
// Free-running read-address counter; wraps silently at the top of the ROM.
module test_mem_addr_ctr
  import test_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) r_addr <= '0;
    else          r_addr <= r_addr + ADDR_W'(1);
  end

  assign addr = r_addr;

endmodule

// File: rtl/test_mem.sv
// Sequential instruction ROM: streams one word per cycle onto the processor
// data-in bus, DIN lagging addr by one cycle.
module test_mem
  import test_mem_pkg::*;
#(
  parameter int unsigned DATA_W = ROM_DATA_W,
  parameter int unsigned ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] DIN
);

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] r_din;

  test_mem_addr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (w_addr)
  );

  // Lookup uses the pre-edge address, which produces the one-cycle lag.
  always_ff @(posedge clk) begin
    if (!reset_n) r_din <= '0;
    else          r_din <= DATA_W'(rom_word(ROM_ADDR_W'(w_addr)));
  end

  assign addr = w_addr;
  assign DIN  = r_din;

endmodule

// File: tb/tb_test_mem.sv
// Directed plus randomized check of test_mem against an edge-count model.
module tb_test_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  addr;
  logic [15:0] DIN;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // rising edges since reset was last released

  test_mem #(
    .DATA_W (16),
    .ADDR_W (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .DIN     (DIN)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] ref_word(input int i);
    logic [15:0] tbl [8];
    tbl = '{16'h2000, 16'h0005, 16'h2200, 16'h0003,
            16'h4200, 16'h6200, 16'h0080, 16'h0000};
    return (i < 8) ? tbl[i] : 16'h0000;
  endfunction

  task automatic check(input string tag);
    logic [4:0]  exp_addr;
    logic [15:0] exp_din;
    exp_addr = 5'(n % 32);
    exp_din  = (n == 0) ? 16'h0000 : ref_word((n - 1) % 32);
    vectors++;
    assert (addr === exp_addr) else begin
      miscompares++;
      $error("FAIL %s addr: got %h expected %h (n=%0d)", tag, addr, exp_addr, n);
    end
    vectors++;
    assert (DIN === exp_din) else begin
      miscompares++;
      $error("FAIL %s DIN: got %h expected %h (n=%0d)", tag, DIN, exp_din, n);
    end
  endtask

  // Called at a falling edge: drive reset, take one rising edge, sample mid-cycle.
  task automatic tick(input bit rst_n, input string tag);
    reset_n = rst_n;
    @(posedge clk);
    if (!rst_n) n = 0;
    else        n++;
    @(negedge clk);
    check(tag);
  endtask

  // Low pulse entirely inside the low clock phase; must be ignored.
  task automatic glitch();
    #3 reset_n = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  initial begin
    // Reset held low for the first 20 ns (one rising edge at 10 ns).
    reset_n = 1'b0;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    check("power_on_reset");

    for (int i = 0; i < 8; i++) tick(1'b1, "first_sweep");

    tick(1'b0, "reset_edge1");
    tick(1'b0, "reset_edge2");

    for (int i = 0; i < 33; i++) tick(1'b1, "wrap_sweep");

    tick(1'b0, "pre_mid_reset");
    for (int i = 0; i < 13; i++) tick(1'b1, "to_addr13");
    tick(1'b0, "mid_sweep_reset");
    tick(1'b1, "after_mid_reset");

    glitch();
    tick(1'b1, "short_pulse_ignored");
    tick(1'b1, "short_pulse_next");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) glitch();
      tick(($urandom_range(0, 19) != 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_mem.md
TEST_MEM -- requirements
Module: test_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of the instruction/data word.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the address width (DEPTH = 2**ADDR_W = 32 words).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, meaning the reset; it is synchronous and active-low.
REQ-005 SHALL have port addr, output, ADDR_W bits, meaning the current read address (the free-running counter value).
REQ-006 SHALL have port DIN, output, DATA_W bits, meaning the registered ROM word supplied to the processor data-in bus.

Function
REQ-007 SHALL contain a read-only 32 x 16 memory with fixed contents: 0:0x2000, 1:0x0005, 2:0x2200, 3:0x0003, 4:0x4200, 5:0x6200, 6:0x0080, 7:0x0000; words 8-31 are 0x0000.
REQ-008 SHALL update the ROM contents only by changing the constant table; there is no write path.
REQ-009 SHALL increment addr by 1 on every rising clk edge while reset_n=1.
REQ-010 SHALL wrap addr from 31 to 0 with no flag, stall or error.
REQ-011 SHALL load DIN <= ROM[addr] on every rising edge while reset_n=1, using the pre-edge addr.
REQ-012 SHALL make DIN lag addr by exactly one cycle: after edge k, DIN = ROM[addr-1 mod 32].
REQ-013 SHALL provide no enable or handshake; output advances unconditionally every cycle.
REQ-014 SHALL never drive X or Z on addr or DIN after the first reset edge.

Reset
REQ-015 SHALL, at a rising edge with reset_n=0, set addr to 0 and DIN to 0x0000.
REQ-016 SHALL take priority for reset over increment and ROM load at any time, including mid-sweep; the next sequence restarts at address 0.
REQ-017 SHALL, at the first edge after reset_n returns high, produce DIN=ROM[0]=0x2000 and addr=1.
REQ-018 SHALL not react asynchronously to reset_n; a low pulse shorter than one clock period that misses an edge has no effect.

Structure
REQ-019 SHALL place DATA_W and ADDR_W defaults and the ROM content table (constant array or function) in package test_mem_pkg.
REQ-020 SHALL implement the address counter as sub-module test_mem_addr_ctr (clk, reset_n, addr) and the ROM plus DIN register in test_mem.
REQ-021 SHALL infer the ROM as a case-statement or constant-array lookup synthesizable to LUT or block ROM.

Verification
REQ-022 SHALL verify that reset_n=0 for 2 edges results in addr=0 and DIN=0x0000.
REQ-023 SHALL verify, after reset release with 8 edges, that DIN reads 0x2000, 0x0005, 0x2200, 0x0003, 0x4200, 0x6200, 0x0080, 0x0000 and addr reads 1..8.
REQ-024 SHALL verify wrap: from reset, after 32 edges addr=0 and DIN=0x0000 (word 31); after 33 edges addr=1 and DIN=0x2000.
REQ-025 SHALL verify mid-sweep reset: with reset_n=0 for 1 edge at addr=13, the response is addr=0 and DIN=0x0000, then on release DIN=0x2000 and addr=1.
REQ-026 SHALL verify with a 20 ns clock and reset_n=0 for the first 20 ns: no X on addr or DIN after the first edge, and the sequence matches REQ-023.
